dmem_ctrl: RTL

Data-memory transaction controller sitting directly downstream of the memory-stage address/store-mask logic. Takes the per-instruction byte address, aligned write data and byte-write mask, runs a valid/ready request plus read-response handshake to the data memory, stalls the pipeline until the access completes, and returns a sign- or zero-extended load result for writeback.

---
 rtl/dmem_ctrl_if.sv | 22 ++
 rtl/dmem_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/dmem_ctrl_if.sv
// Data-memory bus between dmem_ctrl (master) and the memory (slave):
// valid/ready request channel plus a read-response channel.
interface dmem_ctrl_if;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
        input  dmem_req_ready, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_addr, dmem_we, dmem_be, dmem_wdata,
        output dmem_req_ready, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Memory-stage data-memory transaction controller: request/response handshake,
// pipeline stall and load extension. Optional abort timer: define DMEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for a memory instruction; fields captured on mem_accessM
// REQ   | request presented, held stable until dmem_req_ready
// RESP  | load accepted, waiting for dmem_rvalid
// DONE  | access complete, pipeline released, load result valid
module dmem_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_accessM,
    input  logic [6:0]  opcodeM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] mem_adrM,
    input  logic [31:0] mem_wdataM,
    input  logic [3:0]  wea,
    dmem_ctrl_if.master bus,
    output logic        stallM,
    output logic [31:0] load_dataM,
    output logic        load_validM,
    output logic        dmem_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [6:0] OP_STORE = 7'b0100011;

    state_t      r_state;
    state_t      w_next;
    logic [29:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;
    logic [31:0] r_load_data;
    logic [31:0] w_ext;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_timeout;

`ifdef DMEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;
    logic       r_err;

    // Counter runs only while a handshake is outstanding; any state change clears it.
    assign w_timeout = ((r_state == REQ  && !bus.dmem_req_ready) ||
                        (r_state == RESP && !bus.dmem_rvalid)) && (r_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == REQ || r_state == RESP)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    assign dmem_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign dmem_err  = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (mem_accessM) w_next = REQ;
            REQ: begin
                if (bus.dmem_req_ready) w_next = r_we ? DONE : RESP;
                else if (w_timeout)     w_next = DONE;
            end
            // rvalid seen in REQ is ignored: a response is only legal after acceptance
            RESP: if (bus.dmem_rvalid || w_timeout) w_next = DONE;
            DONE: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_byte = bus.dmem_rdata[8*r_lane +: 8];
        w_half = r_lane[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = bus.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_lane      <= '0;
            r_load_data <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && mem_accessM) begin
                r_addr   <= mem_adrM[31:2];
                r_lane   <= mem_adrM[1:0];
                r_wdata  <= mem_wdataM;
                r_be     <= wea;
                r_we     <= (opcodeM == OP_STORE);
                r_funct3 <= funct3M;
            end
            if (w_timeout)
                r_load_data <= '0;
            else if (r_state == RESP && bus.dmem_rvalid)
                r_load_data <= w_ext;
        end
    end

    assign bus.dmem_req_valid = (r_state == REQ);
    assign bus.dmem_addr      = {r_addr, 2'b00};
    assign bus.dmem_we        = r_we;
    assign bus.dmem_be        = r_be;
    assign bus.dmem_wdata     = r_wdata;

    assign stallM      = (r_state == IDLE) ? mem_accessM : (r_state == REQ || r_state == RESP);
    assign load_validM = (r_state == DONE) && !r_we;
    assign load_dataM  = r_load_data;

endmodule
